mcu_scheduler: RTL and testbench

- Merges the separate Y, Cb and Cr 8x8 block streams from the chroma down-sampler into one time-multiplexed block stream in JPEG MCU order (Y0..Y(N-1), Cb, Cr).
- The merged stream feeds a single shared DCT/quantiser pipeline.
- Cb and Cr arrive together beat-for-beat, so the block accepts them jointly and buffers one 64-sample Cr block internally, replaying it after Cb.
- Tags every beat with a component ID and marks block and MCU boundaries.

---
 rtl/mcu_scheduler.sv | 164 ++++++++++++++++
 tb/tb_mcu_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_scheduler.sv
// Merges Y/Cb/Cr 8x8 block streams into one MCU-ordered stream (Y0..Y(N-1), Cb, Cr),
// buffering Cr while Cb passes through. Define MCU_SCHED_CHECK_EN to add the framing_err check.
module mcu_scheduler #(
  parameter int Y_BLOCKS = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] y_axis_tdata,
  input  logic              y_axis_tvalid,
  output logic              y_axis_tready,
  input  logic              y_axis_tlast,
  input  logic [DATA_W-1:0] cb_axis_tdata,
  input  logic              cb_axis_tvalid,
  output logic              cb_axis_tready,
  input  logic              cb_axis_tlast,
  input  logic [DATA_W-1:0] cr_axis_tdata,
  input  logic              cr_axis_tvalid,
  output logic              cr_axis_tready,
  input  logic              cr_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [1:0]        m_axis_tid,
  output logic              mcu_done
`ifdef MCU_SCHED_CHECK_EN
  ,
  output logic              framing_err
`endif
);

  localparam logic [1:0] S_Y  = 2'd0;
  localparam logic [1:0] S_CB = 2'd1;
  localparam logic [1:0] S_CR = 2'd2;
  localparam logic [1:0] BLK_LAST = 2'(Y_BLOCKS - 1);

  logic [1:0]        state_q, state_d;
  logic [5:0]        beat_cnt_q, beat_cnt_d;
  logic [1:0]        blk_cnt_q, blk_cnt_d;
  logic              mcu_done_q, mcu_done_d;
  logic [DATA_W-1:0] cr_buf_q [64];

  logic              m_valid_c;
  logic [DATA_W-1:0] m_data_c;
  logic [1:0]        tid_c;
  logic              y_rdy_c;
  logic              cbcr_rdy_c;
  logic              xfer;
  logic              last_beat;

  assign last_beat = (beat_cnt_q == 6'd63);
  assign xfer      = m_valid_c & m_axis_tready;

  always_comb begin
    m_valid_c  = 1'b0;
    m_data_c   = '0;
    tid_c      = 2'd0;
    y_rdy_c    = 1'b0;
    cbcr_rdy_c = 1'b0;
    case (state_q)
      S_Y: begin
        m_valid_c = y_axis_tvalid;
        m_data_c  = y_axis_tdata;
        tid_c     = 2'd0;
        y_rdy_c   = m_axis_tready;
      end
      S_CB: begin
        m_valid_c  = cb_axis_tvalid & cr_axis_tvalid;
        m_data_c   = cb_axis_tdata;
        tid_c      = 2'd1;
        cbcr_rdy_c = m_axis_tready & cb_axis_tvalid & cr_axis_tvalid;
      end
      S_CR: begin
        m_valid_c = 1'b1;
        m_data_c  = cr_buf_q[beat_cnt_q];
        tid_c     = 2'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    mcu_done_d = 1'b0;
    if (xfer) begin
      beat_cnt_d = beat_cnt_q + 6'd1;
      if (last_beat) begin
        case (state_q)
          S_Y: begin
            if (blk_cnt_q == BLK_LAST) begin
              blk_cnt_d = 2'd0;
              state_d   = S_CB;
            end else begin
              blk_cnt_d = blk_cnt_q + 2'd1;
            end
          end
          S_CB: state_d = S_CR;
          S_CR: begin
            state_d    = S_Y;
            mcu_done_d = 1'b1;
          end
          default: state_d = S_Y;
        endcase
      end
    end
    if (state_q == 2'd3) state_d = S_Y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_Y;
      beat_cnt_q <= 6'd0;
      blk_cnt_q  <= 2'd0;
      mcu_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      mcu_done_q <= mcu_done_d;
    end
  end

  // Cr is captured beat-aligned with Cb and replayed in the following block
  always_ff @(posedge clk) begin
    if (xfer && (state_q == S_CB)) cr_buf_q[beat_cnt_q] <= cr_axis_tdata;
  end

  // Outputs are forced low while reset is held, independent of the clock
  assign m_axis_tvalid  = rst_n & m_valid_c;
  assign m_axis_tdata   = rst_n ? m_data_c : '0;
  assign m_axis_tid     = rst_n ? tid_c : 2'd0;
  assign m_axis_tuser   = rst_n & (beat_cnt_q == 6'd0);
  assign m_axis_tlast   = rst_n & last_beat;
  assign y_axis_tready  = rst_n & y_rdy_c;
  assign cb_axis_tready = rst_n & cbcr_rdy_c;
  assign cr_axis_tready = rst_n & cbcr_rdy_c;
  assign mcu_done       = mcu_done_q;

`ifdef MCU_SCHED_CHECK_EN
  logic framing_err_q, framing_err_d;

  always_comb begin
    framing_err_d = framing_err_q;
    if (xfer && (state_q == S_Y) && (y_axis_tlast != last_beat)) framing_err_d = 1'b1;
    if (xfer && (state_q == S_CB) &&
        ((cb_axis_tlast != last_beat) || (cr_axis_tlast != last_beat))) framing_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) framing_err_q <= 1'b0;
    else        framing_err_q <= framing_err_d;
  end

  assign framing_err = framing_err_q;
`else
  logic unused_tlast;
  assign unused_tlast = y_axis_tlast ^ cb_axis_tlast ^ cr_axis_tlast;
`endif

endmodule

// File: tb/tb_mcu_scheduler.sv
// Directed bench for mcu_scheduler: probe table, full-MCU streams, mid-block reset, Y_BLOCKS=1.
`timescale 1ns/1ps
module tb_mcu_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] y_data, cb_data, cr_data, m_data;
  logic       y_valid, y_last, y_ready;
  logic       cb_valid, cb_last, cb_ready;
  logic       cr_valid, cr_last, cr_ready;
  logic       m_valid, m_ready, m_last, m_user, mcu_done;
  logic [1:0] m_tid;
`ifdef MCU_SCHED_CHECK_EN
  logic       frame_err;
  logic       unused_fe1;
`endif

  logic       y1_valid, cbcr1_valid, m1_ready, m1_valid, m1_done;
  logic [1:0] m1_tid;
  logic       unused_y1_ready, unused_cb1_ready, unused_cr1_ready, unused_m1_last, unused_m1_user;
  logic [7:0] unused_m1_data;

  mcu_scheduler #(.Y_BLOCKS(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .y_axis_tdata(y_data), .y_axis_tvalid(y_valid), .y_axis_tready(y_ready), .y_axis_tlast(y_last),
    .cb_axis_tdata(cb_data), .cb_axis_tvalid(cb_valid), .cb_axis_tready(cb_ready), .cb_axis_tlast(cb_last),
    .cr_axis_tdata(cr_data), .cr_axis_tvalid(cr_valid), .cr_axis_tready(cr_ready), .cr_axis_tlast(cr_last),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
    .m_axis_tuser(m_user), .m_axis_tid(m_tid), .mcu_done(mcu_done)
`ifdef MCU_SCHED_CHECK_EN
    , .framing_err(frame_err)
`endif
  );

  mcu_scheduler #(.Y_BLOCKS(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .y_axis_tdata(8'h00), .y_axis_tvalid(y1_valid), .y_axis_tready(unused_y1_ready), .y_axis_tlast(1'b0),
    .cb_axis_tdata(8'h00), .cb_axis_tvalid(cbcr1_valid), .cb_axis_tready(unused_cb1_ready), .cb_axis_tlast(1'b0),
    .cr_axis_tdata(8'h00), .cr_axis_tvalid(cbcr1_valid), .cr_axis_tready(unused_cr1_ready), .cr_axis_tlast(1'b0),
    .m_axis_tdata(unused_m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready), .m_axis_tlast(unused_m1_last),
    .m_axis_tuser(unused_m1_user), .m_axis_tid(m1_tid), .mcu_done(m1_done)
`ifdef MCU_SCHED_CHECK_EN
    , .framing_err(unused_fe1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ctl = {phase, y_valid, cb_valid, cr_valid, m_ready}; ef = {m_valid, y_ready, cbcr_ready}
  typedef struct {
    logic [4:0] ctl;
    logic [7:0] yd;
    logic [7:0] cbd;
    logic [2:0] ef;
    logic [7:0] emd;
    logic [1:0] etid;
  } probe_t;
  probe_t probes[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    y_valid = 1'b0; y_data = 8'h00; y_last = 1'b0;
    cb_valid = 1'b0; cb_data = 8'h00; cb_last = 1'b0;
    cr_valid = 1'b0; cr_data = 8'h00; cr_last = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_probes(input logic ph);
    for (int i = 0; i < 10; i++) begin
      if (probes[i].ctl[4] == ph) begin
        @(posedge clk); #1;
        y_valid  = probes[i].ctl[3];
        cb_valid = probes[i].ctl[2];
        cr_valid = probes[i].ctl[1];
        m_ready  = probes[i].ctl[0];
        y_data   = probes[i].yd;
        cb_data  = probes[i].cbd;
        cr_data  = 8'h00;
        @(negedge clk);
        chk($sformatf("probe%0d", i),
            32'({m_valid, y_ready, cb_ready, cr_ready, m_data, m_tid, m_user, m_last}),
            32'({probes[i].ef[2], probes[i].ef[1], probes[i].ef[0], probes[i].ef[0],
                 probes[i].emd, probes[i].etid, 1'b1, 1'b0}));
      end
    end
  endtask

  // Streams one MCU (Y 0..255, Cb 0x80+i, Cr 0xC0-i) and checks every output beat in order
  task automatic run_mcu(input int rdy_pct, input int gap_pct, input bit early,
                         input bit frame, input int stop_ci);
    int yi, ci, k, cyc, dones;
    bit bad_early, bad_crr, bad_frame;
    logic [7:0] edata;
    logic [1:0] etid;
    yi = 0; ci = 0; k = 0; cyc = 0; dones = 0;
    bad_early = 1'b0; bad_crr = 1'b0; bad_frame = 1'b0;
    while (k < 384 && cyc < 5000) begin
      @(posedge clk); #1;
      y_valid  = (yi < 256) && (int'($urandom_range(99)) >= gap_pct);
      y_data   = 8'(yi);
      y_last   = ((yi % 64) == 63) || (frame && yi == 10);
      cb_valid = (ci < 64) && (early || int'($urandom_range(99)) >= gap_pct);
      cr_valid = (ci < 64) && (early || int'($urandom_range(99)) >= gap_pct);
      cb_data  = 8'(8'h80 + ci);
      cr_data  = 8'(8'hC0 - ci);
      cb_last  = (ci == 63);
      cr_last  = (ci == 63);
      m_ready  = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clk);
      cyc++;
      if (mcu_done) dones++;
      if (cb_ready !== cr_ready) bad_crr = 1'b1;
      if (cb_ready && yi < 256) bad_early = 1'b1;
`ifdef MCU_SCHED_CHECK_EN
      if (frame_err !== (frame && yi > 10)) bad_frame = 1'b1;
`endif
      if (m_valid && m_ready) begin
        if (k < 256)      begin edata = 8'(k);              etid = 2'd0; end
        else if (k < 320) begin edata = 8'(8'h80 + k - 256); etid = 2'd1; end
        else              begin edata = 8'(8'hC0 - (k - 320)); etid = 2'd2; end
        chk($sformatf("beat%0d", k), 32'({m_tid, m_user, m_last, m_data}),
            32'({etid, (k % 64) == 0, (k % 64) == 63, edata}));
        k++;
      end
      if (y_valid && y_ready) yi++;
      if (cb_ready) ci++;
      if (stop_ci >= 0 && ci >= stop_ci) break;
    end
    if (stop_ci < 0) begin
      chk("all_beats_out", 32'(k), 32'd384);
      repeat (3) begin
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        if (mcu_done) dones++;
      end
      chk("mcu_done_count", 32'(dones), 32'd1);
      chk("cr_ready_eq_cb_ready", 32'(bad_crr), 32'd0);
      chk("cbcr_stalled_during_y", 32'(bad_early), 32'd0);
      if (early && rdy_pct == 100 && gap_pct == 0) chk("zero_bubble_cycles", 32'(cyc), 32'd384);
`ifdef MCU_SCHED_CHECK_EN
      chk("framing_err_timing", 32'(bad_frame), 32'd0);
      chk("framing_err_final", 32'(frame_err), 32'(frame));
`endif
    end
  endtask

  initial begin
    int k1, d1;
    rst_n = 1'b0;
    drive_idle();
    y1_valid = 1'b0; cbcr1_valid = 1'b0; m1_ready = 1'b0;

    probes[0] = '{5'b00000, 8'h00, 8'h00, 3'b000, 8'h00, 2'd0};
    probes[1] = '{5'b01000, 8'h5A, 8'h00, 3'b100, 8'h5A, 2'd0};
    probes[2] = '{5'b00001, 8'h3C, 8'h00, 3'b010, 8'h3C, 2'd0};
    probes[3] = '{5'b00111, 8'h00, 8'h00, 3'b010, 8'h00, 2'd0};
    probes[4] = '{5'b01110, 8'hA5, 8'h77, 3'b100, 8'hA5, 2'd0};
    probes[5] = '{5'b10101, 8'h00, 8'h33, 3'b000, 8'h33, 2'd1};
    probes[6] = '{5'b10110, 8'h00, 8'h44, 3'b100, 8'h44, 2'd1};
    probes[7] = '{5'b10011, 8'h00, 8'h55, 3'b000, 8'h55, 2'd1};
    probes[8] = '{5'b11001, 8'h12, 8'h66, 3'b000, 8'h66, 2'd1};
    probes[9] = '{5'b10111, 8'h00, 8'h99, 3'b101, 8'h99, 2'd1};

    // Outputs held at zero while in reset even with every input active
    y_valid = 1'b1; cb_valid = 1'b1; cr_valid = 1'b1; m_ready = 1'b1;
    y_data = 8'hFF; cb_data = 8'hFF;
    #12;
    chk("reset_outputs",
        32'({m_valid, m_data, m_tid, m_user, m_last, y_ready, cb_ready, cr_ready, mcu_done}), 32'd0);

    do_reset();
    run_probes(1'b0);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      y_valid = 1'b1; y_data = 8'(i); y_last = ((i % 64) == 63); m_ready = 1'b1;
    end
    @(posedge clk); #1;
    drive_idle();
    run_probes(1'b1);

    do_reset();
    run_mcu(100, 0, 1'b1, 1'b0, -1);

    do_reset();
    run_mcu(50, 50, 1'b0, 1'b0, -1);

    // Reset after Cb beat 20, then a fresh Y0 must lead
    do_reset();
    run_mcu(100, 0, 1'b1, 1'b0, 21);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_zero",
        32'({m_valid, m_data, m_tid, m_user, m_last, y_ready, cb_ready, cr_ready, mcu_done}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    y_valid = 1'b1; y_data = 8'h11; cb_valid = 1'b1; cr_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_first",
        32'({m_valid, m_tid, m_user, m_data, y_ready, cb_ready}),
        32'({1'b1, 2'd0, 1'b1, 8'h11, 1'b1, 1'b0}));

    // Y_BLOCKS=1: two MCUs back to back
    do_reset();
    k1 = 0; d1 = 0;
    @(posedge clk); #1;
    y1_valid = 1'b1; cbcr1_valid = 1'b1; m1_ready = 1'b1;
    repeat (386) begin
      @(negedge clk);
      if (m1_valid && m1_ready) begin
        chk($sformatf("yb1_tid%0d", k1), 32'(m1_tid), 32'((k1 / 64) % 3));
        k1++;
      end
      if (m1_done) d1++;
    end
    chk("yb1_mcu_done_count", 32'(d1), 32'd2);
    y1_valid = 1'b0; cbcr1_valid = 1'b0; m1_ready = 1'b0;

`ifdef MCU_SCHED_CHECK_EN
    do_reset();
    run_mcu(100, 20, 1'b0, 1'b1, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
